// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator (hc/vc, syncs, display enable, strobes)
// All flags are decoded from the next counter values so they register in step with hc/vc.
module vga_sync_gen #(
  parameter int H_VISIBLE = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_VISIBLE = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        hsync,
  output logic        vsync,
  output logic        display_en,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("vga_sync_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 2048) begin : g_v_total_chk
    $error("vga_sync_gen: V_TOTAL exceeds 2048");
  end

  // 12-bit thresholds so a sync window ending exactly at 2048 still compares correctly
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS  = 12'(V_VISIBLE);
  localparam logic [11:0] HS_BEG = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] r_hc;
  logic [10:0] r_vc;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_display_en;
  logic        r_line_start;
  logic        r_frame_start;
  logic [7:0]  r_frame_cnt;

  logic        w_h_last;
  logic        w_v_last;
  logic [10:0] w_hc_nxt;
  logic [10:0] w_vc_nxt;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_de_nxt;

  always_comb begin
    w_h_last = ({1'b0, r_hc} == H_LAST);
    w_v_last = ({1'b0, r_vc} == V_LAST);
    w_hc_nxt = w_h_last ? 11'd0 : r_hc + 11'd1;
    w_vc_nxt = r_vc;
    if (w_h_last) begin
      w_vc_nxt = w_v_last ? 11'd0 : r_vc + 11'd1;
    end
    w_hs_act = ({1'b0, w_hc_nxt} >= HS_BEG) && ({1'b0, w_hc_nxt} < HS_END);
    w_vs_act = ({1'b0, w_vc_nxt} >= VS_BEG) && ({1'b0, w_vc_nxt} < VS_END);
    w_de_nxt = ({1'b0, w_hc_nxt} < H_VIS) && ({1'b0, w_vc_nxt} < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_display_en  <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else if (pix_ce) begin
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      r_display_en  <= w_de_nxt;
      r_line_start  <= w_h_last;
      r_frame_start <= w_h_last & w_v_last;
      r_frame_cnt   <= r_frame_cnt + {7'd0, w_h_last & w_v_last};
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hc          = r_hc;
  assign vc          = r_vc;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_en  = r_display_en;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule
